// File: rtl/counter_4bit_down_pkg.sv
// Shared constants for the 4-bit counter family (down counter and its up-counter sibling).
// The all-ones value is both the up counter's terminal value and the down counter's wrap target.
package counter_4bit_down_pkg;

    localparam int         CNT_WIDTH       = 4;
    localparam logic [3:0] CNT_ALL_ONES    = 4'b1111;
    localparam logic [3:0] CNT_RESET_VALUE = CNT_ALL_ONES;

endpackage : counter_4bit_down_pkg

// File: rtl/counter_4bit_down.sv
// Loadable down counter with terminal-count flag, one-cycle borrow pulse on underflow,
// and a selectable wrap-to-all-ones or auto-reload underflow mode.
module counter_4bit_down
    import counter_4bit_down_pkg::*;
#(
    parameter int               WIDTH       = CNT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = CNT_RESET_VALUE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] ZERO_VALUE = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VALUE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] WRAP_VALUE = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             borrow_q;
    logic             borrow_d;
    logic             at_zero_s;

    assign at_zero_s = (count_q == ZERO_VALUE);

    // Next-state priority mux: load, then count down / underflow, else hold.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        borrow_d = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
        end else if (enable) begin
            if (!at_zero_s) begin
                count_d = count_q - ONE_VALUE;
            end else begin
                // Underflow: auto_reload only matters on this edge.
                borrow_d = 1'b1;
                count_d  = auto_reload ? reload_q : WRAP_VALUE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= RESET_VALUE;
            reload_q <= RESET_VALUE;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            borrow_q <= borrow_d;
        end
    end

    assign count  = count_q;
    assign borrow = borrow_q;
    assign zero   = at_zero_s;

endmodule : counter_4bit_down

// File: tb/tb_counter_4bit_down.sv
// Self-checking bench for counter_4bit_down: vector table through a scoreboard queue,
// plus hand-written asynchronous reset checks between clock edges.
module tb_counter_4bit_down;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       load;
    logic [3:0] load_value;
    logic       auto_reload;
    logic [3:0] count;
    logic       zero;
    logic       borrow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       ld;
        logic       en;
        logic       ar;
        logic [3:0] lv;
        logic [3:0] ec;
        logic       eb;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] ec;
        logic       ez;
        logic       eb;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    counter_4bit_down dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .count       (count),
        .zero        (zero),
        .borrow      (borrow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [3:0] ec, input logic ez, input logic eb);
        n_tests++;
        if (count !== ec || zero !== ez || borrow !== eb) begin
            n_fail++;
            $display("FAIL %s: got count=%0d zero=%0b borrow=%0b, expected count=%0d zero=%0b borrow=%0b",
                     name, count, zero, borrow, ec, ez, eb);
        end
    endtask

    task automatic add(input string name, input logic ld, input logic en, input logic ar,
                       input logic [3:0] lv, input logic [3:0] ec, input logic eb);
        vec_t v;
        v.name = name; v.ld = ld; v.en = en; v.ar = ar; v.lv = lv; v.ec = ec; v.eb = eb;
        vecs.push_back(v);
    endtask

    // Applies every queued vector: drive, push expectation, clock, pop and compare.
    task automatic run_table();
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            load        = vecs[i].ld;
            enable      = vecs[i].en;
            auto_reload = vecs[i].ar;
            load_value  = vecs[i].lv;
            e.ec   = vecs[i].ec;
            e.ez   = (vecs[i].ec == 4'd0);
            e.eb   = vecs[i].eb;
            e.name = $sformatf("%s[%0d]", vecs[i].name, i);
            sb.push_back(e);
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
            end else begin
                e = sb.pop_front();
                check(e.name, e.ec, e.ez, e.eb);
            end
        end
        vecs.delete();
        load   = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        load        = 1'b0;
        load_value  = 4'd0;
        auto_reload = 1'b0;

        // Asynchronous reset, visible before any clock edge.
        #10 reset = 1'b1;
        #1 check("reset_async", 4'd15, 1'b0, 1'b0);
        #9 reset = 1'b0;
        @(posedge clock);
        #1 check("reset_hold", 4'd15, 1'b0, 1'b0);

        // Free-run wrap mode.
        for (int i = 1; i <= 15; i++) add("wrap_run", 1'b0, 1'b1, 1'b0, 4'd0, 4'(15 - i), 1'b0);
        add("wrap_under", 1'b0, 1'b1, 1'b0, 4'd0, 4'd15, 1'b1);
        add("wrap_after", 1'b0, 1'b1, 1'b0, 4'd0, 4'd14, 1'b0);
        add("wrap_after", 1'b0, 1'b1, 1'b0, 4'd0, 4'd13, 1'b0);
        add("wrap_after", 1'b0, 1'b1, 1'b0, 4'd0, 4'd12, 1'b0);
        add("wrap_after", 1'b0, 1'b1, 1'b0, 4'd0, 4'd11, 1'b0);

        // Load 3, then auto-reload cycles.
        add("load3", 1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 1'b0);
        for (int r = 0; r < 2; r++) begin
            add("reload_run", 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0);
            add("reload_run", 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0);
            add("reload_run", 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
            add("reload_under", 1'b0, 1'b1, 1'b1, 4'd0, 4'd3, 1'b1);
        end

        // Load beats enable at count 0.
        add("pre_prio", 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0);
        add("pre_prio", 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0);
        add("pre_prio", 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
        add("priority", 1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 1'b0);

        // Hold, then two counts before a mid-cycle reset.
        add("load6", 1'b1, 1'b0, 1'b0, 4'd6, 4'd6, 1'b0);
        for (int i = 0; i < 3; i++) add("hold", 1'b0, 1'b0, 1'b1, 4'd0, 4'd6, 1'b0);
        add("count5", 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 1'b0);
        add("count4", 1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 1'b0);
        run_table();

        #2 reset = 1'b1;
        #1 check("reset_mid", 4'd15, 1'b0, 1'b0);
        #2 reset = 1'b0;

        // Reload register was reset too: underflow reloads 15, not 6.
        for (int i = 1; i <= 15; i++) add("post_reset", 1'b0, 1'b1, 1'b1, 4'd0, 4'(15 - i), 1'b0);
        add("post_reset_under", 1'b0, 1'b1, 1'b1, 4'd0, 4'd15, 1'b1);

        // auto_reload sampled only on the underflow edge.
        add("load2", 1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 1'b0);
        add("ar_sample", 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0);
        add("ar_sample", 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
        add("ar_sample_wrap", 1'b0, 1'b1, 1'b0, 4'd0, 4'd15, 1'b1);

        // Zero reload: back-to-back borrows.
        add("load0", 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) add("zero_reload", 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1);
        run_table();

        // Pending borrow cleared by asynchronous reset.
        load        = 1'b0;
        enable      = 1'b1;
        auto_reload = 1'b1;
        #2 reset = 1'b1;
        #1 check("reset_clears_borrow", 4'd15, 1'b0, 1'b0);
        #2 reset = 1'b0;
        enable = 1'b0;

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_counter_4bit_down
